// File: rtl/trng_health_test.sv
// Continuous SP800-90B health test (repetition count + adaptive proportion) on a raw entropy bit stream.
// Optional per-test failure statistics when TRNG_HT_STATS_EN is defined.
//
// state | meaning
// IDLE  | test disabled, bits ignored, fail_cnt retained
// RUN   | every valid bit is evaluated by RCT and APT
// DEAD  | total failure latched, absorbing until rst_i
module trng_health_test #(
    parameter int RCT_CUTOFF = 32,
    parameter int APT_WINDOW = 512,
    parameter int APT_CUTOFF = 410,
    parameter int MAX_FAILS  = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        bit_i,
    input  logic        bit_valid_i,
    output logic        error_o,
    output logic        total_failure_o,
`ifdef TRNG_HT_STATS_EN
    output logic [15:0] rct_fails_o,
    output logic [15:0] apt_fails_o,
`endif
    output logic        window_done_o
);

    localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
    localparam int WIN_W  = $clog2(APT_WINDOW + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    localparam logic [RCT_W-1:0]  RCT_ONE  = RCT_W'(1);
    localparam logic [RCT_W-1:0]  RCT_LIM  = RCT_W'(RCT_CUTOFF);
    localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1);
    localparam logic [WIN_W-1:0]  WIN_LIM  = WIN_W'(APT_WINDOW);
    localparam logic [WIN_W-1:0]  APT_LIM  = WIN_W'(APT_CUTOFF);
    localparam logic [FAIL_W-1:0] FAIL_ONE = FAIL_W'(1);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAILS);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t            state_q, state_nxt;
    logic [RCT_W-1:0]  rct_q, rct_nxt, rct_upd;
    logic [WIN_W-1:0]  win_q, win_nxt, win_upd;
    logic [WIN_W-1:0]  apt_q, apt_nxt, apt_upd;
    logic [FAIL_W-1:0] fail_q, fail_nxt;
    logic              last_q, last_nxt;
    logic              ref_q, ref_nxt;
    logic              err_nxt, wd_nxt, tf_nxt;
    logic              rct_fail, apt_fail;

    always_comb begin
        state_nxt = state_q;
        rct_nxt   = rct_q;
        win_nxt   = win_q;
        apt_nxt   = apt_q;
        fail_nxt  = fail_q;
        last_nxt  = last_q;
        ref_nxt   = ref_q;
        err_nxt   = 1'b0;
        wd_nxt    = 1'b0;
        tf_nxt    = total_failure_o;
        rct_upd   = rct_q;
        win_upd   = win_q;
        apt_upd   = apt_q;
        rct_fail  = 1'b0;
        apt_fail  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) state_nxt = RUN;
            end
            RUN: begin
                if (bit_valid_i) begin
                    rct_upd  = (bit_i == last_q && rct_q != '0) ? rct_q + RCT_ONE : RCT_ONE;
                    last_nxt = bit_i;
                    if (win_q == '0) begin
                        ref_nxt = bit_i;
                        win_upd = WIN_ONE;
                        apt_upd = WIN_ONE;
                    end else begin
                        win_upd = win_q + WIN_ONE;
                        apt_upd = (bit_i == ref_q) ? apt_q + WIN_ONE : apt_q;
                    end
                    rct_fail = (rct_upd == RCT_LIM);
                    apt_fail = (apt_upd == APT_LIM);
                    if (rct_fail || apt_fail) begin
                        // one event even when both tests trip on the same bit
                        err_nxt  = 1'b1;
                        rct_nxt  = '0;
                        win_nxt  = '0;
                        apt_nxt  = '0;
                        fail_nxt = fail_q + FAIL_ONE;
                        if (fail_q + FAIL_ONE == FAIL_LIM) begin
                            state_nxt = DEAD;
                            tf_nxt    = 1'b1;
                        end
                    end else begin
                        rct_nxt = rct_upd;
                        apt_nxt = apt_upd;
                        if (win_upd == WIN_LIM) begin
                            wd_nxt   = 1'b1;
                            win_nxt  = '0;
                            fail_nxt = '0;
                        end else begin
                            win_nxt = win_upd;
                        end
                    end
                end
                if (!enable_i && state_nxt != DEAD) begin
                    state_nxt = IDLE;
                    rct_nxt   = '0;
                    win_nxt   = '0;
                    apt_nxt   = '0;
                end
            end
            DEAD: begin
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            rct_q           <= '0;
            win_q           <= '0;
            apt_q           <= '0;
            fail_q          <= '0;
            last_q          <= 1'b0;
            ref_q           <= 1'b0;
            error_o         <= 1'b0;
            window_done_o   <= 1'b0;
            total_failure_o <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            rct_q           <= rct_nxt;
            win_q           <= win_nxt;
            apt_q           <= apt_nxt;
            fail_q          <= fail_nxt;
            last_q          <= last_nxt;
            ref_q           <= ref_nxt;
            error_o         <= err_nxt;
            window_done_o   <= wd_nxt;
            total_failure_o <= tf_nxt;
        end
    end

`ifdef TRNG_HT_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rct_fails_o <= '0;
            apt_fails_o <= '0;
        end else begin
            if (rct_fail && rct_fails_o != 16'hFFFF) rct_fails_o <= rct_fails_o + 16'd1;
            if (apt_fail && apt_fails_o != 16'hFFFF) apt_fails_o <= apt_fails_o + 16'd1;
        end
    end
`endif

endmodule
